// File: rtl/jt08_adpcmb_ram.sv
// YM2608 ADPCM-B external RAM responder: turns the chip's read/write strobes into
// req/ack transactions on a byte-wide memory bus, with a one-entry read cache.
module jt08_adpcmb_ram #(
    parameter int AW = 18
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [23:0]   adpcmb_addr,
    input  logic          adpcmb_roe_n,
    input  logic          adpcmb_wr_n,
    input  logic [7:0]    adpcmb_dout,
    output logic [7:0]    adpcmb_din,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic          mem_ack,
    input  logic [7:0]    mem_rdata,
    output logic          busy,
    output logic          ovf
);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD
    } state_t;

    state_t        state;
    logic          roe_hist, wr_hist;
    logic          rd_edge, wr_edge;
    logic          rd_valid, rd_fresh;
    logic          wr_valid, wr_fresh;
    logic [AW-1:0] rd_addr, wr_addr, chip_addr;
    logic [7:0]    wr_data;
    logic          cache_valid, cache_hit;
    logic [AW-1:0] cache_addr;
    logic [7:0]    cache_data;

    assign chip_addr = adpcmb_addr[AW-1:0];
    assign rd_edge   = roe_hist & ~adpcmb_roe_n;
    assign wr_edge   = wr_hist  & ~adpcmb_wr_n;
    assign cache_hit = cache_valid && (cache_addr == rd_addr);
    assign busy      = rd_valid | wr_valid | (state != IDLE);

    generate
        if (AW < 24) begin : g_addr_unused
            logic addr_hi_unused;
            assign addr_hi_unused = ^adpcmb_addr[23:AW];
        end
    endgenerate

    // A slot is "fresh" while it holds data that has not been issued yet; a
    // capture during a transaction keeps the slot alive past that ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the cache payload is a single byte, so it is reset along with
            // everything else; only cache_valid actually matters for correctness.
            state       <= IDLE;
            roe_hist    <= 1'b0;
            wr_hist     <= 1'b0;
            rd_valid    <= 1'b0;
            rd_fresh    <= 1'b0;
            rd_addr     <= '0;
            wr_valid    <= 1'b0;
            wr_fresh    <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            cache_valid <= 1'b0;
            cache_addr  <= '0;
            cache_data  <= '0;
            adpcmb_din  <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            ovf         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; the captures below are
            // placed last on purpose so that a same-edge capture overrides a clear.
            roe_hist <= adpcmb_roe_n;
            wr_hist  <= adpcmb_wr_n;

            case (state)
                IDLE: begin
                    if (wr_valid) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_addr;
                        mem_wdata <= wr_data;
                        wr_fresh  <= 1'b0;
                        state     <= WR;
                    end else if (rd_valid) begin
                        if (cache_hit) begin
                            adpcmb_din <= cache_data;
                            rd_valid   <= 1'b0;
                            rd_fresh   <= 1'b0;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= rd_addr;
                            rd_fresh <= 1'b0;
                            state    <= RD;
                        end
                    end
                end
                WR: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        wr_valid <= wr_fresh;
                        if (cache_valid && (cache_addr == mem_addr)) begin
                            cache_data <= mem_wdata;
                        end
                        state <= IDLE;
                    end
                end
                RD: begin
                    if (mem_ack) begin
                        mem_req     <= 1'b0;
                        adpcmb_din  <= mem_rdata;
                        cache_data  <= mem_rdata;
                        cache_addr  <= mem_addr;
                        cache_valid <= 1'b1;
                        rd_valid    <= rd_fresh;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (rd_edge) begin
                rd_addr  <= chip_addr;
                rd_valid <= 1'b1;
                rd_fresh <= 1'b1;
            end
            if (wr_edge) begin
                wr_addr  <= chip_addr;
                wr_data  <= adpcmb_dout;
                wr_valid <= 1'b1;
                wr_fresh <= 1'b1;
                if (wr_valid) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jt08_adpcmb_ram.sv
// Self-checking bench for jt08_adpcmb_ram: directed scenarios plus randomized
// chip accesses checked against a byte-memory / cache-address reference model.
module tb_jt08_adpcmb_ram;

    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [23:0]   adpcmb_addr;
    logic          adpcmb_roe_n;
    logic          adpcmb_wr_n;
    logic [7:0]    adpcmb_dout;
    logic [7:0]    adpcmb_din;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_ack;
    logic [7:0]    mem_rdata;
    logic          busy;
    logic          ovf;

    jt08_adpcmb_ram #(.AW(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .adpcmb_addr  (adpcmb_addr),
        .adpcmb_roe_n (adpcmb_roe_n),
        .adpcmb_wr_n  (adpcmb_wr_n),
        .adpcmb_dout  (adpcmb_dout),
        .adpcmb_din   (adpcmb_din),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .busy         (busy),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       we;
        int       addr;
        bit [7:0] wdata;
    } req_t;

    int       checks = 0;
    int       errors = 0;
    req_t     req_q[$];
    bit [7:0] sys_mem[int];
    bit [7:0] ref_mem[int];
    bit       cache_v_m;
    int       cache_a_m;
    bit [7:0] din_m;
    int       ack_dly  = 2;
    bit       rand_dly = 1'b0;
    bit       ack_hold = 1'b0;
    bit       spur_ack = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit [7:0] init_val(input int a);
        return 8'(a ^ (a >> 8) ^ 8'h3C);
    endfunction

    function automatic bit [7:0] sys_rd(input int a);
        return sys_mem.exists(a) ? sys_mem[a] : init_val(a);
    endfunction

    function automatic bit [7:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // Memory-side responder: logs every request and acks it after a delay.
    initial begin
        int   cnt;
        bit   pend;
        req_t cur;
        pend      = 1'b0;
        cnt       = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 8'($urandom);
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (!pend && mem_req) begin
                    cur.we    = mem_we;
                    cur.addr  = int'(mem_addr);
                    cur.wdata = mem_wdata;
                    req_q.push_back(cur);
                    pend = 1'b1;
                    cnt  = rand_dly ? int'($urandom_range(3, 0)) : ack_dly;
                end
                if (pend) begin
                    if (cnt > 0) begin
                        cnt--;
                    end else if (!ack_hold) begin
                        mem_ack = 1'b1;
                        if (cur.we) sys_mem[cur.addr] = cur.wdata;
                        else        mem_rdata = sys_rd(cur.addr);
                        pend = 1'b0;
                    end
                end else if (spur_ack) begin
                    mem_ack   = 1'b1;
                    mem_rdata = 8'hEE;
                    spur_ack  = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rd(input logic [23:0] a);
        @(negedge clk);
        adpcmb_addr  = a;
        adpcmb_roe_n = 1'b0;
        @(negedge clk);
        adpcmb_roe_n = 1'b1;
        adpcmb_addr  = 24'($urandom);
    endtask

    task automatic pulse_wr(input logic [23:0] a, input logic [7:0] d);
        @(negedge clk);
        adpcmb_addr = a;
        adpcmb_dout = d;
        adpcmb_wr_n = 1'b0;
        @(negedge clk);
        adpcmb_wr_n = 1'b1;
        adpcmb_addr = 24'($urandom);
        adpcmb_dout = 8'($urandom);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        check(tag, mem_req, 1'b1);
    endtask

    task automatic op_read(input logic [23:0] a);
        int base;
        int ma;
        bit hit;
        base = req_q.size();
        ma   = int'(a[AW-1:0]);
        hit  = cache_v_m && (cache_a_m == ma);
        pulse_rd(a);
        wait_idle("rd_idle");
        check("rd_nreq", req_q.size() - base, hit ? 0 : 1);
        if (!hit && req_q.size() > base) begin
            check("rd_we", 32'(req_q[base].we), 0);
            check("rd_addr", req_q[base].addr, ma);
        end
        din_m = ref_rd(ma);
        check("rd_data", adpcmb_din, din_m);
        cache_v_m = 1'b1;
        cache_a_m = ma;
    endtask

    task automatic op_write(input logic [23:0] a, input logic [7:0] d);
        int base;
        int ma;
        base = req_q.size();
        ma   = int'(a[AW-1:0]);
        pulse_wr(a, d);
        wait_idle("wr_idle");
        check("wr_nreq", req_q.size() - base, 1);
        if (req_q.size() > base) begin
            check("wr_we", 32'(req_q[base].we), 1);
            check("wr_addr", req_q[base].addr, ma);
            check("wr_data", req_q[base].wdata, d);
        end
        ref_mem[ma] = d;
    endtask

    initial begin
        int base;
        rst_n        = 1'b0;
        adpcmb_addr  = '0;
        adpcmb_roe_n = 1'b0;  // held low through reset release: must not count as an edge
        adpcmb_wr_n  = 1'b1;
        adpcmb_dout  = '0;
        cache_v_m    = 1'b0;
        cache_a_m    = 0;
        din_m        = '0;

        repeat (3) @(negedge clk);
        check("rst_din", adpcmb_din, 0);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);

        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        check("held_strobe_busy", busy, 0);
        check("held_strobe_req", mem_req, 0);
        @(negedge clk);
        adpcmb_roe_n = 1'b1;
        repeat (2) tick();

        // First read miss with exact latency
        sys_mem[32'h123] = 8'h5A;
        ref_mem[32'h123] = 8'h5A;
        ack_dly = 2;
        base = req_q.size();
        @(negedge clk);
        adpcmb_addr  = 24'h000123;
        adpcmb_roe_n = 1'b0;
        tick();
        check("t1_req_e1", mem_req, 0);
        check("t1_busy_e1", busy, 1);
        @(negedge clk);
        adpcmb_roe_n = 1'b1;
        tick();
        check("t1_req_e2", mem_req, 1);
        check("t1_we_e2", mem_we, 0);
        check("t1_addr_e2", mem_addr, 18'h00123);
        tick();
        tick();
        check("t1_din_preack", adpcmb_din, 0);
        check("t1_req_preack", mem_req, 1);
        tick();
        check("t1_din_ack", adpcmb_din, 8'h5A);
        check("t1_req_ack", mem_req, 0);
        check("t1_busy_ack", busy, 0);
        check("t1_nreq", req_q.size() - base, 1);
        cache_v_m = 1'b1;
        cache_a_m = 32'h123;
        din_m     = 8'h5A;

        // Repeat read hits the cache
        base = req_q.size();
        @(negedge clk);
        adpcmb_addr  = 24'h000123;
        adpcmb_roe_n = 1'b0;
        tick();
        check("t2_busy_e1", busy, 1);
        check("t2_req_e1", mem_req, 0);
        @(negedge clk);
        adpcmb_roe_n = 1'b1;
        tick();
        check("t2_busy_e2", busy, 0);
        check("t2_din_e2", adpcmb_din, 8'h5A);
        check("t2_nreq", req_q.size() - base, 0);

        // Write updates the cached byte; following read hits
        op_write(24'h000123, 8'h77);
        op_read(24'h000123);

        // Simultaneous read and write strobes: write first, then the read
        base = req_q.size();
        @(negedge clk);
        adpcmb_addr  = 24'h000020;
        adpcmb_dout  = 8'hAA;
        adpcmb_roe_n = 1'b0;
        adpcmb_wr_n  = 1'b0;
        @(negedge clk);
        adpcmb_roe_n = 1'b1;
        adpcmb_wr_n  = 1'b1;
        wait_idle("t4_idle");
        check("t4_nreq", req_q.size() - base, 2);
        if (req_q.size() >= base + 2) begin
            check("t4_first_we", 32'(req_q[base].we), 1);
            check("t4_first_data", req_q[base].wdata, 8'hAA);
            check("t4_second_we", 32'(req_q[base+1].we), 0);
            check("t4_second_addr", req_q[base+1].addr, 32'h20);
        end
        check("t4_din", adpcmb_din, 8'hAA);
        ref_mem[32'h20] = 8'hAA;
        cache_a_m = 32'h20;
        din_m     = 8'hAA;

        // Second write lands while the first is in flight
        ack_dly = 4;
        base = req_q.size();
        pulse_wr(24'h000030, 8'h11);
        wait_req("t5_req");
        check("t5_ovf_before", ovf, 0);
        pulse_wr(24'h000031, 8'h22);
        check("t5_ovf_set", ovf, 1);
        wait_idle("t5_idle");
        check("t5_nreq", req_q.size() - base, 2);
        if (req_q.size() >= base + 2) begin
            check("t5_first_addr", req_q[base].addr, 32'h30);
            check("t5_first_data", req_q[base].wdata, 8'h11);
            check("t5_second_addr", req_q[base+1].addr, 32'h31);
            check("t5_second_data", req_q[base+1].wdata, 8'h22);
        end
        check("t5_ovf_sticky", ovf, 1);
        ref_mem[32'h30] = 8'h11;
        ref_mem[32'h31] = 8'h22;

        // Stray ack while idle changes nothing
        base = req_q.size();
        spur_ack = 1'b1;
        repeat (4) tick();
        check("spur_busy", busy, 0);
        check("spur_din", adpcmb_din, din_m);
        check("spur_nreq", req_q.size() - base, 0);

        // Reset in the middle of a read drops the request and the cache
        ack_dly = 1;
        op_read(24'h000040);
        ack_hold = 1'b1;
        pulse_rd(24'h000041);
        wait_req("t6_req");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_req", mem_req, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_din", adpcmb_din, 0);
        check("t6_rst_ovf", ovf, 0);
        cache_v_m = 1'b0;
        din_m     = '0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        ack_hold = 1'b0;
        repeat (2) tick();
        op_read(24'h000040);

        // Randomized sequential accesses over a small address pool
        rand_dly = 1'b1;
        for (int i = 0; i < 120; i++) begin
            logic [23:0] a;
            a = (24'($urandom) & 24'hFC0000) | (24'h000100 + 24'($urandom_range(7, 0)));
            if ($urandom_range(2, 0) == 0) op_write(a, 8'($urandom));
            else                           op_read(a);
        end
        check("final_ovf", ovf, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
